// File: rtl/operand_sequencer.sv
// Operand sequencer for the registered adder: collects A, B and mode one button press at a time,
// waits out the adder latency, then latches result/overflow for display. Optional DEBOUNCE_EN adds a button debouncer.
module operand_sequencer #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches,
  input  logic             mode_sw,
  input  logic             enter,
  output logic [WIDTH-1:0] operand1,
  output logic [WIDTH-1:0] operand2,
  output logic             mode,
  input  logic [WIDTH-1:0] result,
  input  logic             overflow,
  output logic [WIDTH-1:0] result_latched,
  output logic             overflow_latched,
  output logic             valid,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_WAIT = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  // Button conditioning
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;
  logic press;

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             db_q, db_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

  // db only flips after s2 has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    if (sync2_q == db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db_d     = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      db_q     <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  always_comb begin
    sync1_d = enter;
    sync2_d = sync1_q;
    dly_d   = db_q;
    press   = db_q & ~dly_q;
  end
`else
  always_comb begin
    sync1_d = enter;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
    press   = sync2_q & ~dly_q;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
    end
  end

  // Sequencer FSM and datapath registers
  state_t           state_q, state_d;
  logic             wait_cnt_q, wait_cnt_d;
  logic [WIDTH-1:0] operand1_q, operand1_d;
  logic [WIDTH-1:0] operand2_q, operand2_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             valid_q, valid_d;

  // valid is a level, not a handshake: it rises when a result is captured
  // and drops only when the next operand B is committed.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    operand1_d = operand1_q;
    operand2_d = operand2_q;
    mode_d     = mode_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    case (state_q)
      S_A: begin
        if (press) begin
          operand1_d = switches;
          state_d    = S_B;
        end
      end
      S_B: begin
        if (press) begin
          operand2_d = switches;
          mode_d     = mode_sw;
          valid_d    = 1'b0;
          wait_cnt_d = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // First edge: adder registers the operands; second edge: its output is ready.
        if (!wait_cnt_q) begin
          wait_cnt_d = 1'b1;
        end else begin
          result_d   = result;
          overflow_d = overflow;
          valid_d    = 1'b1;
          wait_cnt_d = 1'b0;
          state_d    = S_SHOW;
        end
      end
      S_SHOW: begin
        if (press) begin
          state_d = S_A;
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_A;
      wait_cnt_q <= 1'b0;
      operand1_q <= '0;
      operand2_q <= '0;
      mode_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      operand1_q <= operand1_d;
      operand2_q <= operand2_d;
      mode_q     <= mode_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign operand1         = operand1_q;
  assign operand2         = operand2_q;
  assign mode             = mode_q;
  assign result_latched   = result_q;
  assign overflow_latched = overflow_q;
  assign valid            = valid_q;
  assign state            = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer wired to a behavioural 3-bit registered adder.
// Compile with +define+DEBOUNCE_EN to exercise the debounced build.
module tb_operand_sequencer;
  localparam int W   = 3;
  localparam int DBC = 4;
`ifdef DEBOUNCE_EN
  localparam int LAT  = 3 + DBC;
  localparam int IDLE = 6 + DBC;
`else
  localparam int LAT  = 3;
  localparam int IDLE = 6;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] switches = '0;
  logic         mode_sw = 1'b0;
  logic         enter = 1'b0;
  logic [W-1:0] operand1, operand2, result_latched;
  logic         mode, overflow_latched, valid;
  logic [1:0]   state;
  logic [W-1:0] adder_res = '0;
  logic         adder_ovf = 1'b0;

  operand_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(DBC)) dut (
    .clock(clock), .reset(reset), .switches(switches), .mode_sw(mode_sw),
    .enter(enter), .operand1(operand1), .operand2(operand2), .mode(mode),
    .result(adder_res), .overflow(adder_ovf), .result_latched(result_latched),
    .overflow_latched(overflow_latched), .valid(valid), .state(state)
  );

  // Clock
  always #5 clock = ~clock;

  // Registered adder stage the sequencer feeds
  always @(posedge clock) begin
    logic [W:0] s;
    s = {1'b0, operand1} + {1'b0, operand2};
    adder_res <= s[W-1:0];
    if (mode) adder_ovf <= (operand1[W-1] == operand2[W-1]) && (s[W-1] != operand1[W-1]);
    else      adder_ovf <= s[W];
  end

  // Checking
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Reference: result and overflow from integer arithmetic on the operand values
  function automatic logic [W:0] ref_add(input int a, input int b, input bit m);
    int sum, sa, sb;
    bit ovf;
    if (m) begin
      sa  = (a >= 4) ? a - 8 : a;
      sb  = (b >= 4) ? b - 8 : b;
      sum = sa + sb;
      ovf = (sum > 3) || (sum < -4);
    end else begin
      sum = a + b;
      ovf = (sum > 7);
    end
    return {ovf, W'((a + b) % 8)};
  endfunction

  // Scoreboard: each fresh valid must match the oldest expected {overflow, result}
  logic [W:0] exp_q[$];
  logic       valid_prev = 1'b0;

  always @(negedge clock) begin
    if (valid === 1'b1 && valid_prev === 1'b0) begin
      if (exp_q.size() > 0) begin
        check("sb_result", {overflow_latched, result_latched}, exp_q.pop_front());
      end else begin
        n_checks++;
        $display("FAIL sb_spurious: got valid with result %0d, expected no result", result_latched);
      end
    end
    valid_prev = valid;
  end

  // Driver tasks (called at a negedge)
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press_to(input logic [1:0] target, output int cyc);
    enter = 1'b1;
    cyc = 0;
    while (state !== target && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    enter = 1'b0;
    idle(IDLE);
  endtask

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         input logic [W-1:0] eres, input logic eovf);
    int cyc, w;
    switches = a;
    press_to(2'b01, cyc);
    check("lat_a", cyc, LAT);
    check("op1_after_a", operand1, a);
    switches = b;
    mode_sw  = m;
    exp_q.push_back({eovf, eres});
    enter = 1'b1;
    cyc = 0;
    while (state !== 2'b10 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    check("lat_b", cyc, LAT);
    check("valid_low_in_wait", valid, 1'b0);
    w = 0;
    while (valid !== 1'b1 && w < 10) begin
      @(negedge clock);
      w++;
    end
    check("wait_to_valid", w, 2);
    check("state_show", state, 2'b11);
    enter = 1'b0;
    switches = ~b;
    mode_sw  = ~m;
    idle(IDLE);
    check("res_latched", result_latched, eres);
    check("ovf_latched", overflow_latched, eovf);
    check("op1_hold", operand1, a);
    check("op2_hold", operand2, b);
    check("mode_hold", mode, m);
    press_to(2'b00, cyc);
    check("back_to_a", state, 2'b00);
    check("valid_kept", valid, 1'b1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic [W-1:0] res;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, changes, first;
    logic [1:0] last;
    logic [W-1:0] ra, rb;
    logic rm;
    logic [W:0] rexp;

    vecs[0] = '{a: 3'b011, b: 3'b110, m: 1'b0, res: 3'b001, ovf: 1'b1};
    vecs[1] = '{a: 3'b011, b: 3'b001, m: 1'b1, res: 3'b100, ovf: 1'b1};
    vecs[2] = '{a: 3'b010, b: 3'b001, m: 1'b0, res: 3'b011, ovf: 1'b0};
    vecs[3] = '{a: 3'b111, b: 3'b001, m: 1'b0, res: 3'b000, ovf: 1'b1};
    vecs[4] = '{a: 3'b100, b: 3'b100, m: 1'b1, res: 3'b000, ovf: 1'b1};
    vecs[5] = '{a: 3'b101, b: 3'b001, m: 1'b1, res: 3'b110, ovf: 1'b0};

    // Reset
    repeat (3) @(negedge clock);
    check("rst_state", state, 2'b00);
    check("rst_op1", operand1, 0);
    check("rst_op2", operand2, 0);
    check("rst_mode", mode, 0);
    check("rst_res", result_latched, 0);
    check("rst_ovf", overflow_latched, 0);
    check("rst_valid", valid, 0);
    reset = 1'b0;
    idle(3);
    check("idle_no_press", state, 2'b00);

    // Directed table
    foreach (vecs[i]) run_txn(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].res, vecs[i].ovf);

    // Randomized against the reference model
    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom_range(0, 7));
      rb = W'($urandom_range(0, 7));
      rm = 1'($urandom_range(0, 1));
      rexp = ref_add(int'(ra), int'(rb), rm);
      run_txn(ra, rb, rm, rexp[W-1:0], rexp[W]);
    end

    // Held button: one transition only, operand1 captured at the acting edge
    switches = 3'b101;
    enter = 1'b1;
    changes = 0;
    first = 0;
    last = state;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock);
      if (state !== last) begin
        changes++;
        if (first == 0) first = i;
      end
      last = state;
      if (i == LAT + 1) switches = 3'b010;
    end
    enter = 1'b0;
    idle(IDLE);
    check("held_changes", changes, 1);
    check("held_lat", first, LAT);
    check("held_state", state, 2'b01);
    check("held_op1", operand1, 3'b101);

`ifndef DEBOUNCE_EN
    // Second press landing in S_WAIT is dropped
    switches = 3'b001;
    mode_sw  = 1'b0;
    exp_q.push_back(ref_add(5, 1, 1'b0));
    enter = 1'b1;
    @(negedge clock);
    enter = 1'b0;
    @(negedge clock);
    enter = 1'b1;
    @(negedge clock);
    check("wp_state_wait", state, 2'b10);
    idle(2);
    check("wp_state_show", state, 2'b11);
    check("wp_valid", valid, 1'b1);
    idle(10);
    check("wp_stays_show", state, 2'b11);
    enter = 1'b0;
    idle(IDLE);
    check("wp_still_show", state, 2'b11);
    press_to(2'b00, cyc);
    switches = 3'b101;
    press_to(2'b01, cyc);
`endif

    // Mid-operation reset in S_B
    check("mr_pre_state", state, 2'b01);
    check("mr_pre_op1", operand1, 3'b101);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mr_state", state, 2'b00);
    check("mr_op1", operand1, 0);
    check("mr_op2", operand2, 0);
    check("mr_valid", valid, 0);
    check("mr_res", result_latched, 0);
    idle(IDLE);
    check("mr_quiet", state, 2'b00);

    // Button held while reset releases: exactly one press
    switches = 3'b110;
    enter = 1'b1;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    changes = 0;
    last = state;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (state !== last) changes++;
      last = state;
    end
    enter = 1'b0;
    idle(IDLE);
    check("rh_changes", changes, 1);
    check("rh_state", state, 2'b01);
    check("rh_op1", operand1, 3'b110);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    idle(IDLE);

`ifdef DEBOUNCE_EN
    // Short glitch is filtered; a 10-cycle press gives one transition DBC later
    enter = 1'b1;
    idle(3);
    enter = 1'b0;
    idle(15);
    check("db_glitch", state, 2'b00);
    switches = 3'b011;
    enter = 1'b1;
    changes = 0;
    first = 0;
    last = state;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (state !== last) begin
        changes++;
        if (first == 0) first = i;
      end
      last = state;
    end
    enter = 1'b0;
    idle(IDLE + 5);
    check("db_changes", changes, 1);
    check("db_lat", first, 3 + DBC);
    check("db_op1", operand1, 3'b011);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
